// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard/forwarding unit: forward-select codes,
// opcode constants and the per-opcode source-usage decode.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [3:0] OP_RTYPE_LO = 4'd0;
    localparam logic [3:0] OP_RTYPE_HI = 4'd2;
    localparam logic [3:0] OP_ALUI_LO  = 4'd3;
    localparam logic [3:0] OP_ALUI_HI  = 4'd4;
    localparam logic [3:0] OP_LW       = 4'd5;
    localparam logic [3:0] OP_SW       = 4'd6;
    localparam logic [3:0] OP_BR_LO    = 4'd7;
    localparam logic [3:0] OP_BR_HI    = 4'd10;
    localparam logic [3:0] OP_JMP      = 4'd11;
    localparam logic [3:0] OP_CALL     = 4'd12;
    localparam logic [3:0] OP_RET      = 4'd13;
    localparam logic [3:0] OP_RS1_ONLY = 4'd14;
    localparam logic [3:0] OP_NONE     = 4'd15;

    // Returns {use_rs1, use_rs2} for the instruction currently in ID.
    function automatic logic [1:0] uses_rs(input logic [3:0] op);
        logic [1:0] u;
        u = 2'b00;
        if (op <= OP_RTYPE_HI)
            u = 2'b11;
        else if (op <= OP_ALUI_HI)
            u = 2'b10;
        else if (op == OP_LW)
            u = 2'b10;
        else if (op == OP_SW)
            u = 2'b11;
        else if (op >= OP_BR_LO && op <= OP_BR_HI)
            u = 2'b11;
        else if (op == OP_RS1_ONLY)
            u = 2'b10;
        return u;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority forward-select for one ID source operand: youngest producer (EXE) wins,
// then MEM, then WB; R0 and unused sources always read the register file.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] rd_ex_i,
    input  logic [REG_ADDR_W-1:0] rd_mem_i,
    input  logic [REG_ADDR_W-1:0] rd_wb_i,
    input  logic                  we_ex_i,
    input  logic                  we_mem_i,
    input  logic                  we_wb_i,
    output logic [1:0]            sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_i && (src_i != '0)) begin
            if (we_ex_i && (rd_ex_i == src_i))
                sel_o = FWD_EX;
            else if (we_mem_i && (rd_mem_i == src_i))
                sel_o = FWD_MEM;
            else if (we_wb_i && (rd_wb_i == src_i))
                sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard unit: operand forwarding selects and a one-shot load-use stall.
// Optional stall/forward event counters are built when HAZARD_STATS_EN is defined.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int OPC_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPC_W-1:0]      opCode,
    input  logic [REG_ADDR_W-1:0] RS1,
    input  logic [REG_ADDR_W-1:0] RS2,
    input  logic [REG_ADDR_W-1:0] Rd2,
    input  logic [REG_ADDR_W-1:0] Rd3,
    input  logic [REG_ADDR_W-1:0] Rd4,
    input  logic                  EX_RegWr,
    input  logic                  MEM_RegWr,
    input  logic                  WB_RegWr,
    input  logic                  EX_MemRd,
    output logic                  stall,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           fwd_cnt
`endif
);

    logic [1:0] use_rs;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       load_use;
    logic       stall_q;
    logic       stall_d;

    assign use_rs = uses_rs(opCode);

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i    (RS1),
        .use_i    (use_rs[1]),
        .rd_ex_i  (Rd2),
        .rd_mem_i (Rd3),
        .rd_wb_i  (Rd4),
        .we_ex_i  (EX_RegWr),
        .we_mem_i (MEM_RegWr),
        .we_wb_i  (WB_RegWr),
        .sel_o    (fwd_a_raw)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i    (RS2),
        .use_i    (use_rs[0]),
        .rd_ex_i  (Rd2),
        .rd_mem_i (Rd3),
        .rd_wb_i  (Rd4),
        .we_ex_i  (EX_RegWr),
        .we_mem_i (MEM_RegWr),
        .we_wb_i  (WB_RegWr),
        .sel_o    (fwd_b_raw)
    );

    // A load in EXE cannot forward its data to ID in time; one bubble resolves it.
    assign load_use = EX_MemRd && EX_RegWr && (Rd2 != '0) &&
                      ((use_rs[1] && (Rd2 == RS1)) || (use_rs[0] && (Rd2 == RS2)));

    always_comb begin
        stall_d  = 1'b0;
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
        if (rst_n) begin
            stall_d  = load_use && !stall_q;
            ForwardA = fwd_a_raw;
            ForwardB = fwd_b_raw;
        end
    end

    assign stall = stall_d;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= 1'b0;
        else
            stall_q <= stall_d;
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (((ForwardA != FWD_RF) || (ForwardB != FWD_RF)) && (fwd_cnt_q != 16'hFFFF))
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized bench for hazard_forward_unit against a table/priority-list model.
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opCode;
    logic [2:0] RS1, RS2, Rd2, Rd3, Rd4;
    logic       EX_RegWr, MEM_RegWr, WB_RegWr, EX_MemRd;
    logic       stall;
    logic [1:0] ForwardA, ForwardB;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, fwd_cnt;
`endif

    hazard_forward_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opCode    (opCode),
        .RS1       (RS1),
        .RS2       (RS2),
        .Rd2       (Rd2),
        .Rd3       (Rd3),
        .Rd4       (Rd4),
        .EX_RegWr  (EX_RegWr),
        .MEM_RegWr (MEM_RegWr),
        .WB_RegWr  (WB_RegWr),
        .EX_MemRd  (EX_MemRd),
        .stall     (stall),
        .ForwardA  (ForwardA),
        .ForwardB  (ForwardB)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        prev_stall = 1'b0;
    logic [15:0] stall_cnt_m = '0;
    logic [15:0] fwd_cnt_m = '0;
    logic        cnt_known = 1'b0;
    // {use_rs1, use_rs2} per opcode 0..15, straight from the opcode usage list.
    logic [1:0]  use_tbl [16] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                                  2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [2:0] src, input logic used);
        logic [2:0] dest [3];
        logic       we   [3];
        dest = '{Rd2, Rd3, Rd4};
        we   = '{EX_RegWr, MEM_RegWr, WB_RegWr};
        if (!used || src == 3'd0) return 2'd0;
        for (int s = 0; s < 3; s++)
            if (we[s] && dest[s] == src) return 2'(s + 1);
        return 2'd0;
    endfunction

    task automatic set_in(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d2, input logic [2:0] d3, input logic [2:0] d4,
                          input logic w2, input logic w3, input logic w4, input logic ld);
        opCode = op; RS1 = a; RS2 = b; Rd2 = d2; Rd3 = d3; Rd4 = d4;
        EX_RegWr = w2; MEM_RegWr = w3; WB_RegWr = w4; EX_MemRd = ld;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        logic [1:0] u, fa, fb;
        logic       hz, st;
        #1;
        u  = use_tbl[opCode];
        fa = rst_n ? ref_fwd(RS1, u[1]) : 2'd0;
        fb = rst_n ? ref_fwd(RS2, u[0]) : 2'd0;
        hz = EX_MemRd && EX_RegWr && (Rd2 != 3'd0) &&
             ((u[1] && Rd2 == RS1) || (u[0] && Rd2 == RS2));
        st = rst_n && hz && !prev_stall;
        check({tag, ".stall"}, {15'd0, stall}, {15'd0, st});
        check({tag, ".fwdA"}, {14'd0, ForwardA}, {14'd0, fa});
        check({tag, ".fwdB"}, {14'd0, ForwardB}, {14'd0, fb});
`ifdef HAZARD_STATS_EN
        if (cnt_known) begin
            check({tag, ".stall_cnt"}, stall_cnt, stall_cnt_m);
            check({tag, ".fwd_cnt"}, fwd_cnt, fwd_cnt_m);
        end
`endif
        @(posedge clk);
        if (!rst_n) begin
            prev_stall  = 1'b0;
            stall_cnt_m = '0;
            fwd_cnt_m   = '0;
            cnt_known   = 1'b1;
        end else begin
            prev_stall = st;
            if (st && stall_cnt_m != 16'hFFFF) stall_cnt_m++;
            if ((fa != 0 || fb != 0) && fwd_cnt_m != 16'hFFFF) fwd_cnt_m++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset held with a load-use hazard present
        set_in(4'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        step("rst_hold0");
        step("rst_hold1");
        rst_n = 1'b1;
        step("rst_release");   // stall allowed immediately
        step("rst_oneshot");

        // Two-source forwarding from different stages
        set_in(4'd0, 3'd3, 3'd4, 3'd3, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fwd_ex_mem");

        // Priority EX > MEM > WB
        set_in(4'd0, 3'd5, 3'd1, 3'd5, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step("prio_ex");
        EX_RegWr = 1'b0;
        step("prio_mem");
        MEM_RegWr = 1'b0;
        step("prio_wb");

        // Load-use on RS2, held: stall, release, stall again
        set_in(4'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("lu_first");
        step("lu_held");
        step("lu_again");

        // JMP uses no sources; R0 never hazards or forwards
        set_in(4'd11, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        step("jmp_nouse");
        set_in(4'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("r0_zero");

        // ALU-imm ignores RS2
        set_in(4'd3, 3'd1, 3'd6, 3'd0, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("aluimm_rs2");

        // Randomized traffic with small register ranges to provoke matches
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) >= 3) begin
                set_in(4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                       3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                       3'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            rst_n = ($urandom_range(0, 29) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
